// File: rtl/lampfpu_fma_sched.sv
// lampfpu_fma_sched: shares one fixed-latency lampFPU FMA datapath between N_REQ requesters.
// Round-robin issue, tag tracking through the datapath latency, and a credit-guarded
// first-word-fall-through result FIFO, so the datapath never needs backpressure.
// Optional build macro LAMPFPU_FMA_SCHED_PRIO_EN gives requester 0 absolute priority.
module lampfpu_fma_sched #(
    parameter int N_REQ     = 4,
    parameter int OP_W      = 64,
    parameter int RES_W     = 40,
    parameter int FMA_LAT   = 2,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*OP_W-1:0]   req_op_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    fma_issue_o,
    output logic [OP_W-1:0]         fma_op_o,
    input  logic                    fma_valid_i,
    input  logic [RES_W-1:0]        fma_res_i,
    output logic                    resp_valid_o,
    output logic [TAG_W-1:0]        resp_tag_o,
    output logic [RES_W-1:0]        resp_data_o,
    input  logic                    resp_ready_i,
    output logic                    err_o
);

    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CREDITS = CW'(RES_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT    = PW'(RES_DEPTH - 1);
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
    localparam logic [TAG_W-1:0] PTR_RESET = TAG_W'(1);
`else
    localparam logic [TAG_W-1:0] PTR_RESET = '0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    state_e                  state_q;
    logic [CW-1:0]           credits_q, credits_d;
    logic [TAG_W-1:0]        rrPtr_q, rrPtr_d;
    logic [TAG_W-1:0]        winner, scanIdx;
    logic                    found, issue;
    logic [OP_W-1:0]         issueOp, opHold_q;
    logic                    pipeValid_q [FMA_LAT];
    logic [TAG_W-1:0]        pipeTag_q   [FMA_LAT];
    logic [TAG_W+RES_W-1:0]  fifoMem_q   [RES_DEPTH];
    logic [TAG_W+RES_W-1:0]  headEntry;
    logic [PW-1:0]           wrPtr_q, rdPtr_q;
    logic [CW-1:0]           count_q;
    logic                    finalValid, push, pop, lost, emptyNext;
    logic                    flushDone_q, err_q;

    // Arbiter: first valid requester at or after the pointer, scanning upward with wrap.
    always_comb begin
        winner  = '0;
        scanIdx = '0;
        found   = 1'b0;
        rrPtr_d = rrPtr_q;
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
        if (req_valid_i[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ - 1; i++) begin
                scanIdx = TAG_W'(1 + ((int'(rrPtr_q) - 1 + i) % (N_REQ - 1)));
                if (!found && req_valid_i[scanIdx]) begin
                    found  = 1'b1;
                    winner = scanIdx;
                end
            end
        end
        if (found && winner != '0) begin
            rrPtr_d = (winner == TAG_W'(N_REQ - 1)) ? TAG_W'(1) : winner + 1'b1;
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            scanIdx = TAG_W'((int'(rrPtr_q) + i) % N_REQ);
            if (!found && req_valid_i[scanIdx]) begin
                found  = 1'b1;
                winner = scanIdx;
            end
        end
        if (found) begin
            rrPtr_d = (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
`endif
    end

    // Flush stops issue immediately, and credits guarantee a FIFO slot for every op issued.
    assign issue   = (state_q != DRAIN) && !flush_i && (credits_q != '0) && found;
    assign issueOp = req_op_i[winner*OP_W +: OP_W];

    // One-hot grant to the winner only in a cycle that really issues.
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_o[k] = issue && (winner == TAG_W'(k));
        end
    end

    assign fma_issue_o = issue;
    assign fma_op_o    = issue ? issueOp : opHold_q;

    // Result pairing: a datapath result is only accepted when the oldest tag is due.
    assign finalValid = pipeValid_q[FMA_LAT-1];
    assign push       = fma_valid_i && finalValid;
    assign lost       = finalValid && !fma_valid_i;
    assign pop        = resp_valid_o && resp_ready_i;
    assign credits_d  = credits_q + CW'(pop) + CW'(lost) - CW'(issue);
    assign emptyNext  = (credits_d == FULL_CREDITS);

    // Tag pipe mirrors the datapath latency so each result can be re-paired with its requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < FMA_LAT; s++) begin
                pipeValid_q[s] <= 1'b0;
                pipeTag_q[s]   <= '0;
            end
        end else begin
            pipeValid_q[0] <= issue;
            pipeTag_q[0]   <= winner;
            for (int s = 1; s < FMA_LAT; s++) begin
                pipeValid_q[s] <= pipeValid_q[s-1];
                pipeTag_q[s]   <= pipeTag_q[s-1];
            end
        end
    end

    // Result FIFO; push and pop together are safe at any occupancy thanks to the credits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < RES_DEPTH; e++) begin
                fifoMem_q[e] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= {pipeTag_q[FMA_LAT-1], fma_res_i};
                wrPtr_q            <= (wrPtr_q == LAST_SLOT) ? '0 : wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == LAST_SLOT) ? '0 : rdPtr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign headEntry    = fifoMem_q[rdPtr_q];
    assign resp_valid_o = (count_q != '0);
    assign resp_tag_o   = headEntry[TAG_W+RES_W-1:RES_W];
    assign resp_data_o  = headEntry[RES_W-1:0];

    // Control FSM with credits, pointer, held operand, flush-done pulse and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            credits_q   <= FULL_CREDITS;
            rrPtr_q     <= PTR_RESET;
            opHold_q    <= '0;
            flushDone_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            credits_q   <= credits_d;
            flushDone_q <= 1'b0;
            if (issue) begin
                rrPtr_q  <= rrPtr_d;
                opHold_q <= issueOp;
            end
            if (fma_valid_i != finalValid) begin
                err_q <= 1'b1;
            end
            if (state_q == DRAIN || flush_i) begin
                if (emptyNext) begin
                    flushDone_q <= 1'b1;
                    state_q     <= IDLE;
                end else begin
                    state_q     <= DRAIN;
                end
            end else begin
                state_q <= emptyNext ? IDLE : BUSY;
            end
        end
    end

    assign flush_done_o = flushDone_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lampfpu_fma_sched.sv
// tb_lampfpu_fma_sched: scoreboard bench for the shared FMA scheduler.
// A small behavioural datapath model returns a known function of each issued operand,
// and expected {tag, result} pairs are queued at grant time and compared at pop time.
`timescale 1ns/1ps
module tb_lampfpu_fma_sched;

    localparam int N_REQ     = 4;
    localparam int OP_W      = 64;
    localparam int RES_W     = 40;
    localparam int FMA_LAT   = 2;
    localparam int RES_DEPTH = 4;
    localparam int TAG_W     = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*OP_W-1:0]  req_op_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   flush_i;
    logic                   flush_done_o;
    logic                   fma_issue_o;
    logic [OP_W-1:0]        fma_op_o;
    logic                   fma_valid_i;
    logic [RES_W-1:0]       fma_res_i;
    logic                   resp_valid_o;
    logic [TAG_W-1:0]       resp_tag_o;
    logic [RES_W-1:0]       resp_data_o;
    logic                   resp_ready_i;
    logic                   err_o;

    int checks = 0;
    int errors = 0;
    int rrExp;

    logic [OP_W-1:0]        reqOp [N_REQ];
    logic [TAG_W+RES_W-1:0] sbQueue [$];
    logic                   dpValid [FMA_LAT];
    logic [OP_W-1:0]        dpOp    [FMA_LAT];

    logic                   sIssue, sRespValid, sErr, sFlushDone, sPop;
    logic [N_REQ-1:0]       sReady;
    logic [OP_W-1:0]        sOp;
    int                     sGrant, sModelGrant;

    lampfpu_fma_sched #(
        .N_REQ(N_REQ), .OP_W(OP_W), .RES_W(RES_W),
        .FMA_LAT(FMA_LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_ready_o(req_ready_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .fma_issue_o(fma_issue_o), .fma_op_o(fma_op_o),
        .fma_valid_i(fma_valid_i), .fma_res_i(fma_res_i),
        .resp_valid_o(resp_valid_o), .resp_tag_o(resp_tag_o), .resp_data_o(resp_data_o),
        .resp_ready_i(resp_ready_i), .err_o(err_o)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Each requester presents its own operand bundle in its slice of the packed bus.
    for (genvar k = 0; k < N_REQ; k++) begin : gPack
        assign req_op_i[k*OP_W +: OP_W] = reqOp[k];
    end

    // The behavioural datapath's result: a fixed scramble of the operand bundle.
    function automatic logic [RES_W-1:0] resFn(input logic [OP_W-1:0] op);
        return op[RES_W-1:0] ^ {op[OP_W-1:OP_W-24], 16'h5A3C};
    endfunction

    // Reference arbitration from the current expected pointer.
    function automatic int expWinner(input logic [N_REQ-1:0] v);
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
        if (v[0]) return 0;
        for (int i = 0; i < N_REQ - 1; i++) begin
            int j = 1 + ((rrExp - 1 + i) % (N_REQ - 1));
            if (v[j]) return j;
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            int j = (rrExp + i) % N_REQ;
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic resetModel();
        sbQueue.delete();
        for (int s = 0; s < FMA_LAT; s++) begin
            dpValid[s] = 1'b0;
            dpOp[s]    = '0;
        end
        fma_valid_i = 1'b0;
        fma_res_i   = '0;
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
        rrExp = 1;
`else
        rrExp = 0;
`endif
    endtask

    // One clock cycle: sample at the falling edge, score grants and pops, advance the datapath model.
    task automatic applyStimulus();
        logic [TAG_W+RES_W-1:0] expEntry;
        @(negedge clk);
        sIssue      = fma_issue_o;
        sReady      = req_ready_o;
        sOp         = fma_op_o;
        sRespValid  = resp_valid_o;
        sErr        = err_o;
        sFlushDone  = flush_done_o;
        sPop        = resp_valid_o && resp_ready_i;
        sModelGrant = expWinner(req_valid_i);
        sGrant      = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_ready_o[k]) sGrant = k;
        end
        if (sIssue && sGrant >= 0) begin
            sbQueue.push_back({TAG_W'(sGrant), resFn(reqOp[sGrant])});
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
            if (sGrant != 0) rrExp = (sGrant == N_REQ - 1) ? 1 : sGrant + 1;
`else
            rrExp = (sGrant + 1) % N_REQ;
`endif
        end
        if (sPop) begin
            checks++;
            if (sbQueue.size() == 0) begin
                errors++;
                $display("[TB] FAIL resp_unexpected got tag=%0d data=%h, required no response", resp_tag_o, resp_data_o);
            end else begin
                expEntry = sbQueue.pop_front();
                if ({resp_tag_o, resp_data_o} !== expEntry) begin
                    errors++;
                    $display("[TB] FAIL resp_pair got %h required %h", {resp_tag_o, resp_data_o}, expEntry);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int s = FMA_LAT - 1; s > 0; s--) begin
            dpValid[s] = dpValid[s-1];
            dpOp[s]    = dpOp[s-1];
        end
        dpValid[0]  = sIssue;
        dpOp[0]     = sOp;
        fma_valid_i = dpValid[FMA_LAT-1];
        fma_res_i   = dpValid[FMA_LAT-1] ? resFn(dpOp[FMA_LAT-1]) : '0;
        if (sIssue && sGrant >= 0) reqOp[sGrant] = {$urandom, $urandom};
    endtask

    // Stop requesting and pop until nothing is buffered or in flight, with a cycle budget.
    task automatic drainPipe();
        bit idle = 1'b0;
        req_valid_i  = '0;
        resp_ready_i = 1'b1;
        flush_i      = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            applyStimulus();
            idle = (sbQueue.size() == 0) && !sRespValid;
            for (int s = 0; s < FMA_LAT; s++) if (dpValid[s]) idle = 1'b0;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("[TB] FAIL drain_timeout got queued=%0d resp_valid=%0b, required empty", sbQueue.size(), sRespValid);
        end
    endtask

    task automatic test_reset();
        req_valid_i  = '0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        rst          = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready_o !== '0)  begin errors++; $display("[TB] FAIL reset_ready got %b required 0", req_ready_o); end
        checks++; if (fma_issue_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue got %b required 0", fma_issue_o); end
        checks++; if (fma_op_o !== '0)     begin errors++; $display("[TB] FAIL reset_op got %h required 0", fma_op_o); end
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b required 0", resp_valid_o); end
        checks++; if ({resp_tag_o, resp_data_o} !== '0) begin errors++; $display("[TB] FAIL reset_resp got %h required 0", {resp_tag_o, resp_data_o}); end
        checks++; if (flush_done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_done got %b required 0", flush_done_o); end
        checks++; if (err_o !== 1'b0)      begin errors++; $display("[TB] FAIL reset_err got %b required 0", err_o); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int expG;
        req_valid_i  = '1;
        resp_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
            expG = 0;
`else
            expG = i % N_REQ;
`endif
            checks++;
            if (!sIssue || sGrant != expG) begin
                errors++;
                $display("[TB] FAIL rr_grant cycle %0d got issue=%0b grant=%0d required grant=%0d", i, sIssue, sGrant, expG);
            end
        end
        drainPipe();
    endtask

    task automatic test_backpressure();
        int issues = 0;
        req_valid_i  = 4'b0100;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            if (sIssue) issues++;
        end
        checks++;
        if (issues != RES_DEPTH || sReady !== '0) begin
            errors++;
            $display("[TB] FAIL credit_limit got issues=%0d ready=%b required issues=%0d ready=0", issues, sReady, RES_DEPTH);
        end
        resp_ready_i = 1'b1;
        applyStimulus();
        resp_ready_i = 1'b0;
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            if (sIssue) issues++;
        end
        checks++;
        if (issues != 1 || !sRespValid) begin
            errors++;
            $display("[TB] FAIL credit_return got issues=%0d resp_valid=%0b required issues=1 resp_valid=1", issues, sRespValid);
        end
    endtask

    task automatic test_full_fifo_flow();
        resp_ready_i = 1'b1;
        applyStimulus();
        checks++;
        if (sIssue || !sPop) begin
            errors++;
            $display("[TB] FAIL full_first got issue=%0b pop=%0b required issue=0 pop=1", sIssue, sPop);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checks++;
            if (!sIssue || !sPop) begin
                errors++;
                $display("[TB] FAIL full_stream cycle %0d got issue=%0b pop=%0b required 1 1", i, sIssue, sPop);
            end
        end
        drainPipe();
    endtask

    task automatic test_flush();
        int pops = 0;
        req_valid_i  = 4'b0010;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checks++;
            if (!sIssue || sGrant != 1) begin
                errors++;
                $display("[TB] FAIL flush_setup got issue=%0b grant=%0d required issue=1 grant=1", sIssue, sGrant);
            end
        end
        flush_i      = 1'b1;
        resp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            flush_i = 1'b0;
            if (sPop) pops++;
            checks++;
            if (sIssue || sFlushDone) begin
                errors++;
                $display("[TB] FAIL flush_drain cycle %0d got issue=%0b done=%0b required 0 0", i, sIssue, sFlushDone);
            end
        end
        req_valid_i = '0;
        applyStimulus();
        checks++;
        if (!sFlushDone || pops != 3) begin
            errors++;
            $display("[TB] FAIL flush_done got done=%0b pops=%0d required done=1 pops=3", sFlushDone, pops);
        end
        flush_i = 1'b1;
        applyStimulus();
        flush_i = 1'b0;
        checks++;
        if (sFlushDone) begin
            errors++;
            $display("[TB] FAIL flush_pulse got done=%0b required 0", sFlushDone);
        end
        applyStimulus();
        checks++;
        if (!sFlushDone) begin
            errors++;
            $display("[TB] FAIL flush_idle got done=%0b required 1", sFlushDone);
        end
        applyStimulus();
        checks++;
        if (sFlushDone) begin
            errors++;
            $display("[TB] FAIL flush_idle_end got done=%0b required 0", sFlushDone);
        end
    endtask

    task automatic test_error();
        fma_valid_i = 1'b1;
        applyStimulus();
        checks++;
        if (sErr) begin
            errors++;
            $display("[TB] FAIL err_early got %0b required 0", sErr);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checks++;
            if (!sErr || sRespValid) begin
                errors++;
                $display("[TB] FAIL err_sticky cycle %0d got err=%0b resp_valid=%0b required 1 0", i, sErr, sRespValid);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_reset got %b required 0", err_o);
        end
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_priority();
        int expG;
        req_valid_i  = 4'b1001;
        resp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
`ifdef LAMPFPU_FMA_SCHED_PRIO_EN
            expG = 0;
`else
            expG = sModelGrant;
`endif
            checks++;
            if (!sIssue || sGrant != expG) begin
                errors++;
                $display("[TB] FAIL prio_grant cycle %0d got issue=%0b grant=%0d required %0d", i, sIssue, sGrant, expG);
            end
        end
        req_valid_i = 4'b1000;
        applyStimulus();
        checks++;
        if (!sIssue || sGrant != 3) begin
            errors++;
            $display("[TB] FAIL prio_switch got issue=%0b grant=%0d required 3", sIssue, sGrant);
        end
        drainPipe();
    endtask

    // Top-level sequence of scenarios followed by the summary.
    initial begin
        for (int k = 0; k < N_REQ; k++) reqOp[k] = {$urandom, $urandom};
        test_reset();
        test_round_robin();
        test_backpressure();
        test_full_fifo_flow();
        test_flush();
        test_error();
        test_priority();
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_left got %0d entries required 0", sbQueue.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
